// File: rtl/brisc_pkg.sv
// BRISC shared datapath types: operand-B select codes.
package brisc_pkg;

    localparam int IMM_CTL_W = 3;

    typedef enum logic [IMM_CTL_W-1:0] {
        IMM_CTL_REG    = 3'd0,
        IMM_CTL_IMM_ZX = 3'd1,
        IMM_CTL_PC_RET = 3'd2,
        IMM_CTL_IMM_SX = 3'd3,
        IMM_CTL_IMM_HI = 3'd4
    } imm_ctl_t;

endpackage

// File: rtl/operand_sel_if.sv
// Decode-to-ALU operand request/response bundle with valid/ready handshakes.
interface operand_sel_if #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8,
    parameter int PC_W   = 8
);
    import brisc_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [IMM_CTL_W-1:0] imm_ctl;
    logic [DATA_W-1:0]    reg_data;
    logic [IMM_W-1:0]     immediate;
    logic [PC_W-1:0]      pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    out_data;
    logic                 out_illegal;

    modport master (
        output in_valid, imm_ctl, reg_data, immediate, pc, out_ready,
        input  in_ready, out_valid, out_data, out_illegal
    );

    modport slave (
        input  in_valid, imm_ctl, reg_data, immediate, pc, out_ready,
        output in_ready, out_valid, out_data, out_illegal
    );

endinterface

// File: rtl/operand_skid_buf.sv
// Operand holding slot: one register (default) or a 2-entry skid buffer
// with registered in_ready when OPSEL_SKID_EN is defined.
module operand_skid_buf #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

`ifdef OPSEL_SKID_EN
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             rdy_q;
    logic             push;
    logic             pop;

    assign in_ready  = rdy_q;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = d0;
    assign push      = in_valid && rdy_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        cnt_nxt = cnt;
        unique case ({push, pop})
            2'b10:   cnt_nxt = cnt + 2'd1;
            2'b01:   cnt_nxt = cnt - 2'd1;
            default: cnt_nxt = cnt;
        endcase
    end

    // d0 is the head; d1 only fills when the head is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 2'd0;
            d0    <= '0;
            d1    <= '0;
            rdy_q <= 1'b1;
        end else begin
            cnt   <= cnt_nxt;
            rdy_q <= (cnt_nxt != 2'd2);
            if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop)))
                d0 <= in_data;
            else if (pop && cnt == 2'd2)
                d0 <= d1;
            if (push && cnt == 2'd1 && !pop)
                d1 <= in_data;
        end
    end
`else
    logic             v;
    logic [WIDTH-1:0] d;
    logic             push;

    assign in_ready  = !v || out_ready;
    assign out_valid = v;
    assign out_data  = d;
    assign push      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= 1'b0;
            d <= '0;
        end else if (push) begin
            v <= 1'b1;
            d <= in_data;
        end else if (out_ready) begin
            v <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/operand_sel_stage.sv
// Registered ALU operand-B select stage (reg/imm/PC+offset).
// Build option OPSEL_SKID_EN selects a 2-entry skid buffer.
module operand_sel_stage #(
    parameter int DATA_W    = 16,
    parameter int IMM_W     = 8,
    parameter int PC_W      = 8,
    parameter int PC_OFFSET = 3
) (
    input logic         clk,
    input logic         rst_n,
    operand_sel_if.slave bus
);
    import brisc_pkg::*;

    logic [DATA_W-1:0] sel_data;
    logic              sel_ill;
    logic [PC_W-1:0]   pc_sum;
    logic [DATA_W:0]   buf_out;

    // carry out of the PC add is intentionally dropped
    assign pc_sum = bus.pc + PC_W'(PC_OFFSET);

    always_comb begin
        sel_data = bus.reg_data;
        sel_ill  = 1'b0;
        unique case (bus.imm_ctl)
            IMM_CTL_REG:    sel_data = bus.reg_data;
            IMM_CTL_IMM_ZX: sel_data = DATA_W'(bus.immediate);
            IMM_CTL_PC_RET: sel_data = DATA_W'(pc_sum);
            IMM_CTL_IMM_SX: sel_data = DATA_W'($signed(bus.immediate));
            IMM_CTL_IMM_HI:
                sel_data = DATA_W'(bus.immediate) << (DATA_W - IMM_W);
            default: begin
                sel_data = bus.reg_data;
                sel_ill  = 1'b1;
            end
        endcase
    end

    operand_skid_buf #(
        .WIDTH (DATA_W + 1)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({sel_ill, sel_data}),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (buf_out)
    );

    assign bus.out_data    = buf_out[DATA_W-1:0];
    assign bus.out_illegal = buf_out[DATA_W];

endmodule

// File: tb/tb_operand_sel_stage.sv
// Directed self-checking bench for operand_sel_stage.
module tb_operand_sel_stage;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    operand_sel_if #(.DATA_W(16), .IMM_W(8), .PC_W(8)) bus ();

    operand_sel_stage #(
        .DATA_W    (16),
        .IMM_W     (8),
        .PC_W      (8),
        .PC_OFFSET (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctl;
        logic [15:0] rd;
        logic [7:0]  imm;
        logic [7:0]  pc;
        logic [15:0] exp_d;
        logic        exp_i;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.imm_ctl   = 3'd0;
        bus.reg_data  = 16'h0;
        bus.immediate = 8'h0;
        bus.pc        = 8'h0;
        bus.out_ready = 1'b1;
    endtask

    // Streams n REG operands; out_ready low for cycles [s_lo, s_hi].
    task automatic run_stream(input logic [15:0] base, input int n,
                              input int s_lo, input int s_hi,
                              input int max_cyc, output int cyc_used);
        int sent;
        int popped;
        int occ;
        logic exp_rdy;
        sent = 0;
        popped = 0;
        occ = 0;
        cyc_used = max_cyc;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (sent < n);
            bus.imm_ctl   = 3'd0;
            bus.reg_data  = base + 16'(sent);
            bus.immediate = 8'h5A;
            bus.out_ready = !(cyc >= s_lo && cyc <= s_hi);
            #1;
`ifdef OPSEL_SKID_EN
            exp_rdy = (occ != 2);
`else
            exp_rdy = (occ == 0) || bus.out_ready;
`endif
            chk("stream_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("stream_out_valid", 32'(bus.out_valid), 32'(occ != 0));
            if (bus.out_valid && bus.out_ready) begin
                chk("stream_data", 32'(bus.out_data),
                    32'(base + 16'(popped)));
                chk("stream_illegal", 32'(bus.out_illegal), 32'd0);
                popped++;
                occ--;
            end
            if (bus.in_valid && bus.in_ready) begin
                sent++;
                occ++;
            end
            if (popped == n) begin
                cyc_used = cyc + 1;
                break;
            end
        end
        chk("stream_count", 32'(popped), 32'(n));
        @(negedge clk);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int used;
        tests = 0;
        fails = 0;

        vecs[0]  = '{3'd1, 16'hDEAD, 8'hA5, 8'h00, 16'h00A5, 1'b0};
        vecs[1]  = '{3'd3, 16'hDEAD, 8'hA5, 8'h00, 16'hFFA5, 1'b0};
        vecs[2]  = '{3'd4, 16'hDEAD, 8'hA5, 8'h00, 16'hA500, 1'b0};
        vecs[3]  = '{3'd2, 16'hDEAD, 8'h00, 8'h10, 16'h0013, 1'b0};
        vecs[4]  = '{3'd2, 16'hDEAD, 8'h00, 8'hFE, 16'h0001, 1'b0};
        vecs[5]  = '{3'd2, 16'hDEAD, 8'h00, 8'hFC, 16'h00FF, 1'b0};
        vecs[6]  = '{3'd0, 16'hBEEF, 8'hA5, 8'h77, 16'hBEEF, 1'b0};
        vecs[7]  = '{3'd3, 16'hDEAD, 8'h7F, 8'h00, 16'h007F, 1'b0};
        vecs[8]  = '{3'd6, 16'h1234, 8'hA5, 8'h10, 16'h1234, 1'b1};
        vecs[9]  = '{3'd0, 16'h5678, 8'hA5, 8'h10, 16'h5678, 1'b0};
        vecs[10] = '{3'd5, 16'h0001, 8'hFF, 8'h10, 16'h0001, 1'b1};
        vecs[11] = '{3'd7, 16'hFFFF, 8'h01, 8'h10, 16'hFFFF, 1'b1};

        // reset held with traffic offered
        idle();
        bus.in_valid = 1'b1;
        bus.reg_data = 16'h0042;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        chk("first_data", 32'(bus.out_data), 32'h0042);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("first_drained", 32'(bus.out_valid), 32'd0);

        foreach (vecs[i]) begin
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            bus.imm_ctl   = vecs[i].ctl;
            bus.reg_data  = vecs[i].rd;
            bus.immediate = vecs[i].imm;
            bus.pc        = vecs[i].pc;
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.reg_data = 16'hCAFE;
            bus.imm_ctl  = 3'd1;
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_data", i), 32'(bus.out_data),
                32'(vecs[i].exp_d));
            chk($sformatf("vec%0d_illegal", i), 32'(bus.out_illegal),
                32'(vecs[i].exp_i));
            @(negedge clk);
        end

        // 8 operands with a 3-cycle output stall mid-stream
        run_stream(16'd1, 8, 3, 5, 40, used);

        // full-rate streaming: 16 outputs after 1-cycle fill
        run_stream(16'h0100, 16, -1, -1, 40, used);
        chk("throughput_cycles", 32'(used), 32'd17);

        // reset mid-stream
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.reg_data = 16'h0200 + 16'(k);
            @(negedge clk);
        end
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_data", 32'(bus.out_data), 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid0", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_valid1", 32'(bus.out_valid), 32'd0);
        run_stream(16'h0300, 2, -1, -1, 10, used);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
